// File: rtl/maxnet_scheduler.sv
// Iteration controller for a 4-neuron Maxnet sharing one 4-input PLU.
// Runs Jacobi iterations (ISSUE/WAIT per neuron), commits, then checks for a single survivor.
//
// state  | meaning
// IDLE   | waiting for start after reset
// LOAD   | clamp latched inputs into y
// ISSUE  | one-cycle plu_start for neuron n
// WAIT   | hold weights/activations until plu_done
// COMMIT | copy shadow results into y, bump iteration count
// CHECK  | convergence / iteration-limit decision
// DONE   | results held until next start
module maxnet_scheduler #(
    parameter logic [31:0]       W_SELF   = 32'h3F800000,
    parameter logic [31:0]       W_INH    = 32'hBE4CCCCD,
    parameter int                ITER_W   = 8,
    parameter logic [ITER_W-1:0] MAX_ITER = ITER_W'(64)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       x1,
    input  logic [31:0]       x2,
    input  logic [31:0]       x3,
    input  logic [31:0]       x4,
    output logic              busy,
    output logic              done,
    output logic [31:0]       y1,
    output logic [31:0]       y2,
    output logic [31:0]       y3,
    output logic [31:0]       y4,
    output logic [1:0]        winner,
    output logic              winner_valid,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count,
    output logic              plu_start,
    input  logic              plu_done,
    output logic [31:0]       plu_w1,
    output logic [31:0]       plu_w2,
    output logic [31:0]       plu_w3,
    output logic [31:0]       plu_w4,
    output logic [31:0]       plu_a1,
    output logic [31:0]       plu_a2,
    output logic [31:0]       plu_a3,
    output logic [31:0]       plu_a4,
    input  logic [31:0]       plu_out
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] ISSUE  = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] COMMIT = 3'd4;
    localparam logic [2:0] CHECK  = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    logic [2:0]  state;
    logic [1:0]  n;
    logic [31:0] y_q   [4];
    logic [31:0] shd_q [4];

    logic [2:0]  nz_cnt;
    logic [1:0]  nz_idx;
    logic [1:0]  max_idx;
    logic [30:0] max_val;
    logic        pl_active;

    // Magnitude bits only, so -0.0 is treated as zero and the compare is unsigned.
    always_comb begin
        nz_cnt  = '0;
        nz_idx  = '0;
        max_idx = '0;
        max_val = y_q[0][30:0];
        for (int k = 0; k < 4; k++) begin
            if (y_q[k][30:0] != '0) begin
                nz_cnt = nz_cnt + 3'd1;
                nz_idx = 2'(k);
            end
            if (y_q[k][30:0] > max_val) begin
                max_val = y_q[k][30:0];
                max_idx = 2'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            n            <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
            timeout      <= 1'b0;
            iter_count   <= '0;
            for (int k = 0; k < 4; k++) begin
                y_q[k]   <= '0;
                shd_q[k] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Shadow registers double as the input latch until LOAD.
                        shd_q[0]     <= x1;
                        shd_q[1]     <= x2;
                        shd_q[2]     <= x3;
                        shd_q[3]     <= x4;
                        iter_count   <= '0;
                        timeout      <= 1'b0;
                        winner_valid <= 1'b0;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    for (int k = 0; k < 4; k++)
                        y_q[k] <= shd_q[k][31] ? 32'd0 : shd_q[k];
                    n     <= '0;
                    state <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (plu_done) begin
                        shd_q[n] <= plu_out[31] ? 32'd0 : plu_out;
                        if (n == 2'd3) begin
                            state <= COMMIT;
                        end else begin
                            n     <= n + 2'd1;
                            state <= ISSUE;
                        end
                    end
                end
                COMMIT: begin
                    for (int k = 0; k < 4; k++)
                        y_q[k] <= shd_q[k];
                    if (iter_count != '1)
                        iter_count <= iter_count + 1'b1;
                    state <= CHECK;
                end
                CHECK: begin
                    if (nz_cnt <= 3'd1) begin
                        winner_valid <= (nz_cnt == 3'd1);
                        winner       <= (nz_cnt == 3'd1) ? nz_idx : 2'd0;
                        state        <= DONE;
                    end else if (iter_count == MAX_ITER) begin
                        timeout      <= 1'b1;
                        winner       <= max_idx;
                        winner_valid <= 1'b0;
                        state        <= DONE;
                    end else begin
                        n     <= '0;
                        state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == LOAD) || (state == ISSUE) || (state == WAIT) ||
                       (state == COMMIT) || (state == CHECK);
    assign done      = (state == DONE);
    assign plu_start = (state == ISSUE);
    assign pl_active = (state == ISSUE) || (state == WAIT);

    assign plu_w1 = (pl_active && n == 2'd0) ? W_SELF : W_INH;
    assign plu_w2 = (pl_active && n == 2'd1) ? W_SELF : W_INH;
    assign plu_w3 = (pl_active && n == 2'd2) ? W_SELF : W_INH;
    assign plu_w4 = (pl_active && n == 2'd3) ? W_SELF : W_INH;

    assign y1 = y_q[0];
    assign y2 = y_q[1];
    assign y3 = y_q[2];
    assign y4 = y_q[3];

    assign plu_a1 = y_q[0];
    assign plu_a2 = y_q[1];
    assign plu_a3 = y_q[2];
    assign plu_a4 = y_q[3];

endmodule

// File: tb/tb_maxnet_scheduler.sv
// Bench for maxnet_scheduler: float PLU model with random latency and a
// high-level Maxnet reference computed directly from the iteration rules.
module tb_maxnet_scheduler;

    localparam logic [31:0] W_SELF = 32'h3F800000;
    localparam logic [31:0] W_INH  = 32'hBE4CCCCD;
    localparam int          MAXI   = 8;

    logic        clk = 1'b0;
    logic        rst, start, plu_done, busy, done, winner_valid, timeout, plu_start;
    logic [31:0] x1, x2, x3, x4, y1, y2, y3, y4, plu_out;
    logic [31:0] plu_w1, plu_w2, plu_w3, plu_w4, plu_a1, plu_a2, plu_a3, plu_a4;
    logic [1:0]  winner;
    logic [7:0]  iter_count;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int rst_gen = 0;
    int max_lat = 0;

    logic [31:0] m_y [4];
    int          m_iter, m_win;
    logic        m_valid, m_to;

    maxnet_scheduler #(.ITER_W(8), .MAX_ITER(8'(MAXI))) dut (
        .clk(clk), .rst(rst), .start(start),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .busy(busy), .done(done),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4),
        .winner(winner), .winner_valid(winner_valid), .timeout(timeout),
        .iter_count(iter_count), .plu_start(plu_start), .plu_done(plu_done),
        .plu_w1(plu_w1), .plu_w2(plu_w2), .plu_w3(plu_w3), .plu_w4(plu_w4),
        .plu_a1(plu_a1), .plu_a2(plu_a2), .plu_a3(plu_a3), .plu_a4(plu_a4),
        .plu_out(plu_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic real r_abs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'd0) return 0.0;
        b = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        int          e;
        logic [22:0] m;
        logic [28:0] rem;
        logic [31:0] v;
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        if (b[62:52] == 11'd0 || e <= 0) return {b[63], 31'd0};
        m   = b[51:29];
        rem = b[28:0];
        v   = {b[63], 8'(e), m};
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) v = v + 32'd1;
        return v;
    endfunction

    function automatic logic [31:0] plu_calc(input logic [31:0] w [4], input logic [31:0] a [4]);
        real s = 0.0;
        for (int j = 0; j < 4; j++) s = s + f2r(w[j]) * f2r(a[j]);
        return r2f(s);
    endfunction

    // Reference: plain Jacobi Maxnet with clamp, ReLU, convergence and limit rules.
    task automatic model_run(input logic [31:0] xi [4]);
        logic [31:0] y [4];
        logic [31:0] ny [4];
        logic [31:0] w [4];
        logic [31:0] r;
        int          cnt, last, best;
        bit          fin;
        for (int k = 0; k < 4; k++) y[k] = xi[k][31] ? 32'd0 : xi[k];
        m_iter = 0; m_win = 0; m_valid = 1'b0; m_to = 1'b0; fin = 1'b0;
        while (!fin) begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 4; j++) w[j] = (j == k) ? W_SELF : W_INH;
                r = plu_calc(w, y);
                ny[k] = r[31] ? 32'd0 : r;
            end
            y = ny;
            m_iter++;
            cnt = 0; last = 0; best = 0;
            for (int k = 0; k < 4; k++) begin
                if (y[k][30:0] != 31'd0) begin cnt++; last = k; end
                if (y[k][30:0] > y[best][30:0]) best = k;
            end
            if (cnt <= 1) begin
                m_valid = (cnt == 1); m_win = (cnt == 1) ? last : 0; fin = 1'b1;
            end else if (m_iter == MAXI) begin
                m_to = 1'b1; m_win = best; fin = 1'b1;
            end
        end
        m_y = y;
    endtask

    // PLU: result ready 1+lat cycles after plu_start; checks operand stability meanwhile.
    always begin
        logic [31:0] ca [4];
        logic [31:0] cw [4];
        logic [31:0] ew [4];
        logic [31:0] r;
        int g, lat, idx;
        @(negedge clk);
        if (rst && plu_start) begin
            g   = rst_gen;
            idx = pulse_cnt % 4;
            pulse_cnt++;
            ca = '{plu_a1, plu_a2, plu_a3, plu_a4};
            cw = '{plu_w1, plu_w2, plu_w3, plu_w4};
            for (int k = 0; k < 4; k++) ew[k] = (k == idx) ? W_SELF : W_INH;
            chk("plu_w_issue", {cw[0], cw[1], cw[2], cw[3]}, {ew[0], ew[1], ew[2], ew[3]});
            r   = plu_calc(cw, ca);
            lat = $urandom_range(0, max_lat);
            @(posedge clk);
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                if (g == rst_gen)
                    chk("plu_a_stable", {plu_a1, plu_a2, plu_a3, plu_a4}, {ca[0], ca[1], ca[2], ca[3]});
                @(posedge clk);
            end
            #1;
            if (g == rst_gen) begin
                plu_done = 1'b1;
                plu_out  = r;
            end
            @(negedge clk);
            if (g == rst_gen)
                chk("plu_aw_at_done", {plu_a1, plu_a2, plu_a3, plu_a4, plu_w1, plu_w2, plu_w3, plu_w4},
                    {ca[0], ca[1], ca[2], ca[3], cw[0], cw[1], cw[2], cw[3]});
            @(posedge clk);
            #1;
            plu_done = 1'b0;
            plu_out  = $urandom;
        end
    end

    task automatic start_run(input logic [31:0] xs [4]);
        model_run(xs);
        pulse_cnt = 0;
        x1 = xs[0]; x2 = xs[1]; x3 = xs[2]; x4 = xs[3];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(1));
        chk("done_after_start", 128'(done), 128'(0));
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!done && cyc < 4000) begin @(negedge clk); cyc++; end
        chk({tag, "_reached_done"}, 128'(done), 128'(1));
        chk({tag, "_busy_low"}, 128'(busy), 128'(0));
        chk({tag, "_pulses"}, 128'(pulse_cnt), 128'(4 * int'(iter_count)));
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_y"}, {y1, y2, y3, y4}, {m_y[0], m_y[1], m_y[2], m_y[3]});
        chk({tag, "_iter"}, 128'(iter_count), 128'(m_iter));
        chk({tag, "_win"}, 128'(winner), 128'(m_win));
        chk({tag, "_valid"}, 128'(winner_valid), 128'(m_valid));
        chk({tag, "_timeout"}, 128'(timeout), 128'(m_to));
    endtask

    function automatic logic [31:0] rnd_f32();
        logic s;
        int   e;
        if ($urandom_range(0, 5) == 0) return 32'd0;
        s = ($urandom_range(0, 3) == 0);
        e = $urandom_range(123, 128);
        return {s, 8'(e), 23'($urandom)};
    endfunction

    initial begin
        logic [31:0] xs [4];
        int cyc;
        rst = 1'b0; start = 1'b0; plu_done = 1'b0; plu_out = '0;
        x1 = '0; x2 = '0; x3 = '0; x4 = '0;
        repeat (2) @(negedge clk);
        chk("rst_flags", {busy, done, winner_valid, timeout, plu_start, winner, iter_count}, 128'(0));
        chk("rst_y", {y1, y2, y3, y4}, 128'(0));
        chk("rst_w", {plu_w1, plu_w2, plu_w3, plu_w4}, {W_INH, W_INH, W_INH, W_INH});
        rst = 1'b1;
        @(negedge clk);

        // x=(1.0, 0.5, 0.25, 0.0), 1-cycle PLU
        xs = '{32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h0};
        start_run(xs);
        cyc = 0;
        while (iter_count != 8'd1 && cyc < 200) begin @(negedge clk); cyc++; end
        chk("s1_it1_y1_085", 128'((r_abs(f2r(y1) - 0.85) < 1.0e-6) ? 1 : 0), 128'(1));
        chk("s1_it1_y2y3y4", {y2, y3, y4}, {32'h3E800000, 32'h0, 32'h0});
        wait_done("s1");
        chk("s1_y1_0784", 128'((r_abs(f2r(y1) - 0.784) < 1.0e-5) ? 1 : 0), 128'(1));
        chk("s1_fixed", {y2, y3, y4, 6'(winner), 1'b0, winner_valid, iter_count, 7'd0, timeout},
            {32'h0, 32'h0, 32'h0, 6'd0, 1'b0, 1'b1, 8'd3, 7'd0, 1'b0});
        check_model("s1");
        repeat (3) @(negedge clk);
        chk("s1_hold", {done, y1, 30'd0, winner}, {1'b1, m_y[0], 30'd0, 2'(m_win)});

        // single nonzero input converges in one iteration
        xs = '{32'h0, 32'h0, 32'h40000000, 32'h0};
        start_run(xs);
        wait_done("s2");
        chk("s2_fixed", {y1, y2, y3, y4, 6'(winner), winner_valid, iter_count},
            {32'h0, 32'h0, 32'h40000000, 32'h0, 6'd2, 1'b1, 8'd1});

        // negative input clamped at LOAD
        xs = '{32'hBF800000, 32'h0, 32'h0, 32'h0};
        start_run(xs);
        wait_done("s3");
        chk("s3_fixed", {y1, y2, y3, y4, winner_valid, timeout, iter_count},
            {32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 8'd1});

        // symmetric pair never converges
        xs = '{32'h3F800000, 32'h3F800000, 32'h0, 32'h0};
        start_run(xs);
        wait_done("s4");
        chk("s4_fixed", {timeout, iter_count, 6'(winner), winner_valid},
            {1'b1, 8'(MAXI), 6'd0, 1'b0});
        check_model("s4");

        // random PLU latency, directed then random activations
        max_lat = 5;
        xs = '{32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h0};
        start_run(xs);
        wait_done("s1_lat");
        check_model("s1_lat");
        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < 4; k++) xs[k] = rnd_f32();
            start_run(xs);
            wait_done($sformatf("rnd%0d", t));
            check_model($sformatf("rnd%0d", t));
        end

        // reset in WAIT of iteration 2
        xs = '{32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h0};
        start_run(xs);
        cyc = 0;
        while (!(pulse_cnt >= 5 && iter_count == 8'd1 && !plu_start) && cyc < 400) begin
            @(negedge clk); cyc++;
        end
        chk("mid_wait_reached", 128'(cyc < 400 ? 1 : 0), 128'(1));
        #1 rst = 1'b0;
        rst_gen++;
        #1;
        chk("mid_rst_flags", {busy, done, winner_valid, timeout, plu_start, winner, iter_count}, 128'(0));
        chk("mid_rst_y", {y1, y2, y3, y4}, 128'(0));
        chk("mid_rst_w", {plu_w1, plu_w2, plu_w3, plu_w4}, {W_INH, W_INH, W_INH, W_INH});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_start", 128'(plu_start), 128'(0));
        end
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_idle", {busy, done}, 128'(0));

        // fresh run with a start pulse while busy that must be ignored
        start_run(xs);
        repeat (7) @(negedge clk);
        x1 = 32'h40400000; x2 = 32'h0; x3 = 32'h0; x4 = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("rerun");
        check_model("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/maxnet_scheduler.md
Name: maxnet_scheduler

Overview:
- Iteration controller for a 4-neuron Maxnet built on a single shared 4-input PLU (multiply-accumulate of four weights by four activations, start/done handshake).
- Loads four IEEE-754 single-precision activations and runs synchronous (Jacobi) Maxnet iterations.
- Each iteration time-multiplexes the PLU across the four neurons, applies ReLU, commits the results and checks for convergence.
- Sits between the top-level start/result interface and the PLU instance.

Parameters:
- W_SELF, 32'h3F800000, self-excitation weight (1.0), driven on the diagonal.
- W_INH, 32'hBE4CCCCD, lateral inhibition weight (-0.2), driven off-diagonal.
- MAX_ITER, 8'd64, iteration limit before forced termination.
- ITER_W, 8, width of the iteration counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled in IDLE or DONE only.
- x1..x4  input  32  initial activations, sampled on the cycle start is accepted.
- busy  output  1  high from the cycle after start is accepted until DONE is entered.
- done  output  1  level; high while in DONE.
- y1..y4  output  32  current activation registers.
- winner  output  2  index (0..3) of the surviving nonzero neuron.
- winner_valid  output  1  exactly one nonzero activation at termination.
- timeout  output  1  run ended because MAX_ITER was reached.
- iter_count  output  ITER_W  number of completed iterations.
- plu_start  output  1  one-cycle PLU start pulse.
- plu_done  input  1  PLU result valid.
- plu_w1..plu_w4  output  32  PLU weights.
- plu_a1..plu_a4  output  32  PLU activations; always equal to y1..y4.
- plu_out  input  32  PLU result.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; y*, shadow registers, winner, winner_valid, timeout, iter_count, busy, done and plu_start all 0. plu_w* = W_INH. A mid-run reset aborts immediately, with no further plu_start.
- FSM states: IDLE, LOAD, ISSUE, WAIT, COMMIT, CHECK, DONE. Neuron index n is 2 bits.
- IDLE/DONE, start=1: latch x*, go to LOAD. Clear iter_count, timeout and winner_valid; done drops. start is ignored in all other states.
- LOAD (1 cycle): y_k = 0 if x_k[31]=1 (negative inputs clamped), else x_k. n=0. Go to ISSUE.
- ISSUE (1 cycle): plu_start=1. plu_w_k = W_SELF for k==n, else W_INH. plu_w* stays stable through WAIT. Go to WAIT.
- WAIT: plu_done is sampled only in WAIT, never in the ISSUE cycle. On plu_done=1:
  - shadow[n] = 0 if plu_out[31]=1 (ReLU), else plu_out.
  - If n==3, go to COMMIT; otherwise n++ and go to ISSUE.
  - No timeout on PLU latency.
- COMMIT (1 cycle): y* = shadow* simultaneously; iter_count++ (saturating).
- CHECK (1 cycle): a neuron is nonzero iff y_k[30:0] != 0 (so -0.0 counts as zero).
  - count ≤ 1: go to DONE. winner_valid = (count==1); winner = index of that neuron, else 0.
  - count > 1 and iter_count == MAX_ITER: go to DONE, timeout=1. winner = lowest index with maximum y (unsigned compare of bits [30:0]); winner_valid=0.
  - Otherwise n=0 and go to ISSUE.
- DONE: hold all outputs until start or reset.
- Exactly four plu_start pulses per iteration; plu_a* never changes while the PLU is busy.
- Minimum iteration latency is 4×(1 + PLU latency) + 2 cycles.

Test Plan:
- Exact float PLU model, 1-cycle latency. x=(1.0, 0.5, 0.25, 0.0) -> after iteration 1, y=(0.85, 0.25, 0, 0). Done after 3 iterations with y1≈0.784, y2..y4=0, winner=0, winner_valid=1, iter_count=3, timeout=0.
- x=(0, 0, 2.0, 0) -> done after 1 iteration, y3=32'h40000000, winner=2, winner_valid=1, iter_count=1.
- x=(-1.0, 0, 0, 0) -> clamped at LOAD; done after 1 iteration, all y=0, winner_valid=0.
- x=(1.0, 1.0, 0, 0), MAX_ITER=8 -> symmetric, never converges. timeout=1, iter_count=8, winner=0, winner_valid=0.
- Random PLU latency 0..5 cycles per op -> results identical to the 1-cycle case. Exactly 4 plu_start pulses per iteration, and plu_a* is stable from ISSUE until plu_done.
- Assert rst=0 in WAIT of iteration 2 -> all outputs 0 in the same cycle, state IDLE. A new start runs the first scenario correctly. start pulsed while busy is ignored.
